// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with byte/half/word loads and stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of truncating the address.
module dmem_responder #(
    parameter int REG_WIDTH   = 32,
    parameter int ADR_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADR_WIDTH-1:0] req_adr,
    input  logic [REG_WIDTH-1:0] req_wdata,
    input  logic [2:0]           req_funct3,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [REG_WIDTH-1:0] wdata;
    logic [2:0]           funct3;
    logic [REG_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]        idx;
    logic [1:0]           lane;
    logic [REG_WIDTH-1:0] word, wr_word, ld_data, bmask, bdata;
    logic [7:0]           lb;
    logic [15:0]          lh;
    logic                 oor, bad_f3, misal, err, done;

    always_comb begin
        idx     = adr[AW+1:2];
        lane    = adr[1:0];
        word    = mem[idx];
        lb      = 8'(word >> {lane, 3'b000});
        lh      = lane[1] ? word[31:16] : word[15:0];
        ld_data = funct3[1:0] == 2'b00 ? {{24{lb[7] & ~funct3[2]}}, lb} :
                  funct3[1:0] == 2'b01 ? {{16{lh[15] & ~funct3[2]}}, lh} : word;
        bmask   = 32'hFF << {lane, 3'b000};
        bdata   = {24'b0, wdata[7:0]} << {lane, 3'b000};
        wr_word = funct3 == 3'b000 ? (word & ~bmask) | bdata :
                  funct3 == 3'b001 ? (lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
                  wdata;
        oor     = (adr >> (AW + 2)) != '0;
        bad_f3  = we ? funct3 > 3'b010 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
        misal   = (funct3[1:0] == 2'b01 && lane[0]) || (funct3[1:0] == 2'b10 && lane != 2'b00);
`else
        misal   = 1'b0;
`endif
        err     = oor | bad_f3 | misal;
        done    = state == WAIT && cnt == CW'(1);
    end

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk)
        if (!reset && done && we && !err) mem[idx] <= wr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we     <= req_we;
                    adr    <= req_adr;
                    wdata  <= req_wdata;
                    funct3 <= req_funct3;
                    cnt    <= CW'(RD_LATENCY);
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (done) begin
                        rsp_rdata <= (we || err) ? '0 : ld_data;
                        rsp_err   <= err;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
